// File: rtl/eeprom_req_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM master between NREQ requesters.
// One transaction in flight; start strobe stretched for the slow SCL domain,
// completion awaited with a timeout, result returned to the winning requester.
module eeprom_req_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned NEWD_CYCLES = 24,
  parameter int unsigned TIMEOUT     = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              m_newd,
  output logic              m_wr,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic              m_done
);

  localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] NW_LAST = 16'(NEWD_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   win_idx, win_n;
  logic [15:0]     cnt, cnt_n;
  logic [NREQ-1:0] grant_n, ack_n;
  logic [7:0]      rdata_n;
  logic            err_n;
  logic            newd_n, wr_n;
  logic [6:0]      addr_n;
  logic [7:0]      wdata_n;

  logic            done_s1, done_s2, done_d;
  logic            done_rise;
  logic            found;
  logic [IW-1:0]   pick;

  assign done_rise = done_s2 & ~done_d;

  // Two-flop synchroniser on m_done plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_d  <= 1'b0;
    end else begin
      done_s1 <= m_done;
      done_s2 <= done_s1;
      done_d  <= done_s2;
    end
  end

  // Round-robin search: first active request starting at ptr, wrapping mod NREQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      int unsigned   cand;
      logic [IW-1:0] cidx;
      cand = 32'(ptr) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      win_idx   <= '0;
      cnt       <= '0;
      grant     <= '0;
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      m_newd    <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      win_idx   <= win_n;
      cnt       <= cnt_n;
      grant     <= grant_n;
      ack       <= ack_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
      busy      <= (state_n != S_IDLE);
      m_newd    <= newd_n;
      m_wr      <= wr_n;
      m_addr    <= addr_n;
      m_wdata   <= wdata_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win_idx;
    cnt_n   = cnt;
    grant_n = grant;
    ack_n   = '0;
    rdata_n = rsp_rdata;
    err_n   = rsp_err;
    newd_n  = m_newd;
    wr_n    = m_wr;
    addr_n  = m_addr;
    wdata_n = m_wdata;
    case (state)
      S_IDLE: begin
        if (found) begin
          win_n        = pick;
          grant_n      = '0;
          grant_n[pick] = 1'b1;
          wr_n         = req_wr[pick];
          addr_n       = req_addr[7*int'(pick) +: 7];
          wdata_n      = req_wdata[8*int'(pick) +: 8];
          newd_n       = 1'b1;
          cnt_n        = '0;
          state_n      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt == NW_LAST) begin
          newd_n  = 1'b0;
          cnt_n   = '0;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_WAIT: begin
        cnt_n = cnt + 16'd1;
        // done takes priority over a timeout landing in the same cycle
        if (done_rise) begin
          rdata_n = m_wr ? 8'h00 : m_rdata;
          err_n   = 1'b0;
          ack_n   = grant;
          state_n = S_RESP;
        end else if (cnt == TO_LAST) begin
          rdata_n = 8'h00;
          err_n   = 1'b1;
          ack_n   = grant;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        grant_n = '0;
        ptr_n   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
